arm_multicycle_ctrl: RTL and testbench
======================================

# arm_multicycle_ctrl

- Control unit for the multicycle ARM datapath: the next step after the single-cycle core.
- Sequences one shared instruction/data memory, the register file, the ALU and the PC over 2–5 cycles per instruction.
- Holds the NZCV flags and evaluates the condition field.
- Drives every mux select and write enable of the datapath; the instruction register and datapath registers stay external.

## Interface

Parameters:
- TIMEOUT, 16, cycles a memory access may wait for MemReady before Fault; used only with ARM_MC_WAIT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 = reset.
- Instr  in  32  instruction register contents; valid from DECODE onward.
- ALUFlags  in  4  ALU {N,Z,C,V} of the current cycle.
- MemReady  in  1  memory access complete; present only with ARM_MC_WAIT_EN.
- PCWrite  out  1  PC load enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register file write enable.
- IRWrite  out  1  instruction register load enable.
- AdrSrc  out  1  0 = PC, 1 = ALU result register.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- ALUSrcA  out  1  0 = Rn, 1 = PC.
- ALUSrcB  out  2  00 Rm, 01 ExtImm, 10 constant 4.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  equals Instr[27:26].
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01).
- Fault  out  1  one-cycle timeout pulse; tied 0 without the macro.
- State  out  4  current state encoding, for debug.

## Operation

Decode fields:
- Op = Instr[27:26], Funct = Instr[25:20], Rd = Instr[15:12], Cond = Instr[31:28].

States and transitions (encoding in parentheses):
- FETCH(0) → DECODE.
- DECODE(1) → next state by Op:
  - Op 01 → MEMADR.
  - Op 00 with Funct[5]=0 → EXECUTER.
  - Op 00 with Funct[5]=1 → EXECUTEI.
  - Op 10 → BRANCH.
  - Op 11 → FETCH (undefined; no writes).
- MEMADR(2) → MEMRD if Funct[0]=1, else MEMWR.
- MEMRD(3) → MEMWB(4) → FETCH.
- MEMWR(5) → FETCH.
- EXECUTER(6) / EXECUTEI(7) → ALUWB(8) → FETCH.
- BRANCH(9) → FETCH.

Per-state controls (all unlisted enables are 0):
- FETCH: AdrSrc 0, IRWrite 1, PCWrite 1, ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10.
- DECODE: ALUSrcA 1, ALUSrcB 10, ADD, ResultSrc 10.
- MEMADR: ALUSrcA 0, ALUSrcB 01, ADD.
- MEMRD: AdrSrc 1, ResultSrc 00.
- MEMWB: ResultSrc 01, RegWrite.
- MEMWR: AdrSrc 1, ResultSrc 00, MemWrite.
- EXECUTER: ALUSrcB 00; ALU decode active.
- EXECUTEI: ALUSrcB 01; ALU decode active.
- ALUWB: ResultSrc 00, RegWrite.
- BRANCH: ALUSrcA 0, ALUSrcB 01, ADD, ResultSrc 10, PCWrite.

ALU decode (EXECUTE states only):
- Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other code → ADD with no flag write.
- With S = Funct[0] = 1:
  - ADD/SUB update NZCV.
  - AND/ORR update NZ only.

Condition handling:
- CondEx is latched at the end of DECODE from the flags register and held until the next FETCH.
- Conditions: EQ, NE, CS, CC, MI, PL, VS, VC, HI (C&~Z), LS, GE (N==V), LT, GT (~Z&N==V), LE, AL = 1; Cond 1111 → 0.
- RegWrite, MemWrite, flag updates and the BRANCH PCWrite are gated by CondEx.
- In MEMWB or ALUWB with Rd==15, PCWrite = CondEx.

## Timing

Latency in cycles, FETCH to FETCH:
- LDR 5; STR 4; data-processing 4; B 3; undefined 2.

Output and flag timing:
- Outputs are combinational from state, Instr and CondEx.
- Flags register on the rising edge ending EXECUTER/EXECUTEI.

Reset (reset=0):
- Next state is FETCH; flags cleared to 0000; CondEx = 0.
- All write enables (PCWrite, MemWrite, RegWrite, IRWrite) are forced to 0 while reset=0.
- Other outputs take their FETCH values.
- Fault = 0; State = 0.
- Reset mid-instruction aborts it with no further writes; execution resumes with FETCH the cycle after release.

## Configuration

ARM_MC_WAIT_EN defined:
- Adds MemReady. FETCH, MEMRD and MEMWR hold until MemReady=1.
- In FETCH, IRWrite and PCWrite assert only in the MemReady cycle.
- MemWrite stays high during the MEMWR hold.
- A wait counter clears on state entry.
- On reaching TIMEOUT without MemReady:
  - Fault pulses for one cycle.
  - The state returns to FETCH with no writes.
  - The PC is not advanced, so the fetch retries.
- TIMEOUT=0 disables the timeout.

ARM_MC_WAIT_EN undefined:
- No MemReady port; every access completes in one cycle.
- Fault is constant 0; TIMEOUT is ignored.

## Test plan

- Hold reset=0 for 3 cycles → State=0, all write enables 0. Release → first cycle IRWrite=1, PCWrite=1.
- LDR 0xE5900000 → State 0,1,2,3,4,0; AdrSrc=1 in state 3; RegWrite=1 only in state 4 with ResultSrc=01.
- ADDS 0xE0921003 with ALUFlags=0100 in EXECUTER → ALUControl=00; then BEQ 0x0A000002 → PCWrite=1 in BRANCH; BNE 0x1A000002 → PCWrite=0.
- With Z=1, STRNE 0x15801000 → sequence 0,1,2,5,0 with MemWrite=0 throughout.
- SUB 0xE042F001 → ALUControl=01 in state 6; ALUWB asserts RegWrite=1 and PCWrite=1.
- With ARM_MC_WAIT_EN and TIMEOUT=4:
  - MemReady low 3 cycles in FETCH → State=0 held, IRWrite=0; MemReady high → IRWrite=PCWrite=1 for one cycle.
  - MemReady never asserted → Fault=1 on the 4th wait cycle, no enables asserted.

Source files
------------

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: instruction sequencing FSM, NZCV flags, condition check, datapath selects.
// Optional memory wait/timeout handling is enabled by defining ARM_MC_WAIT_EN.
module arm_multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
`ifdef ARM_MC_WAIT_EN
  input  logic        MemReady,
`endif
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        Fault,
  output logic [3:0]  State
);

  // state    | meaning
  // FETCH    | read instruction at PC, PC += 4
  // DECODE   | read registers, latch condition result
  // MEMADR   | compute load/store address
  // MEMRD    | read data memory
  // MEMWB    | write loaded data to Rd
  // MEMWR    | write data memory
  // EXECUTER | ALU op with register operand
  // EXECUTEI | ALU op with immediate operand
  // ALUWB    | write ALU result to Rd
  // BRANCH   | load branch target into PC
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      state, state_nxt, dec_state;
  logic [3:0]  flags;
  logic        cond_ex;
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cond;
  logic        rd_pc;
  logic [1:0]  alu_ctl;
  logic        alu_known, alu_arith;
  logic        ready, timeout;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cond  = Instr[31:28];
  assign rd_pc = (Instr[15:12] == 4'hF);

  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = cf;
      4'b0011: cond_eval = ~cf;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = cf & ~z;
      4'b1001: cond_eval = ~cf | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Unrecognised ALU codes fall back to ADD but never touch the flags.
  always_comb begin
    alu_ctl   = 2'b00;
    alu_known = 1'b1;
    case (funct[4:1])
      4'b0100: alu_ctl = 2'b00;
      4'b0010: alu_ctl = 2'b01;
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
      default: alu_known = 1'b0;
    endcase
    alu_arith = (funct[4:1] == 4'b0100) || (funct[4:1] == 4'b0010);
  end

`ifdef ARM_MC_WAIT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] wait_cnt;
  logic             waiting;

  assign waiting = reset && ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR));
  assign ready   = MemReady;
  assign timeout = waiting && !MemReady && (TIMEOUT != 0) && (wait_cnt == '0);

  // Down-counter reloads whenever the FSM moves on, so every access gets a full budget.
  always_ff @(posedge clk) begin
    if (!reset)
      wait_cnt <= CNT_LOAD;
    else if (waiting && !MemReady && !timeout)
      wait_cnt <= wait_cnt - 1'b1;
    else
      wait_cnt <= CNT_LOAD;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{Instr[19:16], Instr[11:0], (TIMEOUT != 0)};
  assign ready      = 1'b1;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:    state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          2'b01:   state_nxt = S_MEMADR;
          2'b00:   state_nxt = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_nxt = S_BRANCH;
          default: state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_nxt = ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWR:    state_nxt = ready ? S_FETCH : S_MEMWR;
      S_EXECUTER: state_nxt = S_ALUWB;
      S_EXECUTEI: state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BRANCH:   state_nxt = S_FETCH;
      default:    state_nxt = S_FETCH;
    endcase
    if (timeout)
      state_nxt = S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      flags   <= 4'b0000;
      cond_ex <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE)
        cond_ex <= cond_eval(cond, flags);
      // Logical ops leave C and V untouched.
      if (((state == S_EXECUTER) || (state == S_EXECUTEI)) && cond_ex && funct[0] && alu_known) begin
        flags[3:2] <= ALUFlags[3:2];
        if (alu_arith)
          flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // While reset is held the outputs decode as FETCH with every write enable suppressed.
  assign dec_state = reset ? state : S_FETCH;
  assign State     = dec_state;
  assign Fault     = timeout;
  assign ImmSrc    = op;
  assign RegSrc    = {(op == 2'b01), (op == 2'b10)};

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (dec_state)
      S_FETCH: begin
        IRWrite   = ready;
        PCWrite   = ready;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR:   ALUSrcB = 2'b01;
      S_MEMRD:    AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_pc;
      end
      S_MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex & ~timeout;
      end
      S_EXECUTER: ALUControl = alu_ctl;
      S_EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_ctl;
      end
      S_ALUWB: begin
        RegWrite = cond_ex;
        PCWrite  = cond_ex & rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Table-driven bench for arm_multicycle_ctrl: per-cycle expected outputs plus reset and wait corner cases.
module tb_arm_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
`ifdef ARM_MC_WAIT_EN
  logic        MemReady;
`endif
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, Fault;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  arm_multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
`ifdef ARM_MC_WAIT_EN
    .MemReady(MemReady),
`endif
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Fault(Fault), .State(State)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  flg;
    logic [3:0]  st;
    logic [3:0]  en;   // {PCWrite, MemWrite, RegWrite, IRWrite}
    logic        adr;
    logic [1:0]  res;
    logic        sa;
    logic [1:0]  sb;
    logic [1:0]  alu;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] i, input logic [3:0] fl, input logic [3:0] st,
                     input logic [3:0] en, input logic adr, input logic [1:0] res,
                     input logic sa, input logic [1:0] sb, input logic [1:0] alu);
    vec_t v;
    v.instr = i; v.flg = fl; v.st = st; v.en = en; v.adr = adr;
    v.res = res; v.sa = sa; v.sb = sb; v.alu = alu;
    vecs.push_back(v);
  endtask

  task automatic add_fd(input logic [31:0] i);
    add(i, 4'b0, 4'd0, 4'b1001, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00);
    add(i, 4'b0, 4'd1, 4'b0000, 1'b0, 2'b10, 1'b1, 2'b10, 2'b00);
  endtask

  task automatic add_branch(input logic [31:0] i, input logic taken);
    add_fd(i);
    add(i, 4'b0, 4'd9, {taken, 3'b000}, 1'b0, 2'b10, 1'b0, 2'b01, 2'b00);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [3:0] enables();
    return {PCWrite, MemWrite, RegWrite, IRWrite};
  endfunction

  initial begin
    logic [31:0] got_v, exp_v;
    logic [1:0]  opx;

    localparam logic [31:0] LDR   = 32'hE5900000;
    localparam logic [31:0] ADDS  = 32'hE0921003;
    localparam logic [31:0] STRNE = 32'h15801000;
    localparam logic [31:0] SUBPC = 32'hE042F001;
    localparam logic [31:0] ORRSI = 32'hE3901000;
    localparam logic [31:0] UNKS  = 32'hE1F01000;
    localparam logic [31:0] UNDEF = 32'hEC000000;

    add_fd(LDR);
    add(LDR, 4'b0, 4'd2, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00);
    add(LDR, 4'b0, 4'd3, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    add(LDR, 4'b0, 4'd4, 4'b0010, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00);
    add_fd(ADDS);
    add(ADDS, 4'b0100, 4'd6, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    add(ADDS, 4'b0000, 4'd8, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    add_branch(32'h0A000002, 1'b1);   // BEQ, Z=1
    add_branch(32'h1A000002, 1'b0);   // BNE
    add_fd(STRNE);
    add(STRNE, 4'b0, 4'd2, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b00);
    add(STRNE, 4'b0, 4'd5, 4'b0000, 1'b1, 2'b00, 1'b0, 2'b00, 2'b00);
    add_fd(SUBPC);
    add(SUBPC, 4'b1111, 4'd6, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01);
    add(SUBPC, 4'b0000, 4'd8, 4'b1010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    // ORRS imm with ALU NZCV=1010 -> flags become 1000 (C,V kept)
    add_fd(ORRSI);
    add(ORRSI, 4'b1010, 4'd7, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b01, 2'b11);
    add(ORRSI, 4'b0000, 4'd8, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    add_branch(32'h2A000000, 1'b0);   // BCS, C=0
    add_branch(32'h4A000000, 1'b1);   // BMI, N=1
    // Unknown ALU code with S=1 must not write flags
    add_fd(UNKS);
    add(UNKS, 4'b0100, 4'd6, 4'b0000, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    add(UNKS, 4'b0000, 4'd8, 4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00);
    add_branch(32'h0A000000, 1'b0);   // BEQ, Z=0
    add_branch(32'hDA000000, 1'b1);   // BLE, N!=V
    add_branch(32'hAA000000, 1'b0);   // BGE
    add_fd(UNDEF);
    add_branch(32'hEA000000, 1'b1);   // BAL
    add_branch(32'hFA000000, 1'b0);   // cond 1111 never

    reset    = 1'b0;
    Instr    = SUBPC;
    ALUFlags = 4'b0000;
`ifdef ARM_MC_WAIT_EN
    MemReady = 1'b1;
`endif

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_state", {28'h0, State}, 32'd0);
      chk("reset_enables", {28'h0, enables()}, 32'd0);
      @(negedge clk);
    end
    chk("reset_fault", {31'h0, Fault}, 32'd0);

    reset = 1'b1;
    foreach (vecs[n]) begin
      Instr    = vecs[n].instr;
      ALUFlags = vecs[n].flg;
      #1;
      opx   = vecs[n].instr[27:26];
      got_v = {10'h0, State, PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, Fault};
      exp_v = {10'h0, vecs[n].st, vecs[n].en, vecs[n].adr, vecs[n].res, vecs[n].sa,
               vecs[n].sb, vecs[n].alu, opx, (opx == 2'b01), (opx == 2'b10), 1'b0};
      chk($sformatf("vec%0d", n), got_v, exp_v);
      @(negedge clk);
    end

    // Reset in the middle of an LDR, then check flags were cleared with BMI
    Instr = LDR;
    @(negedge clk);
    @(negedge clk);
    #1 chk("mid_memadr", {28'h0, State}, 32'd2);
    reset = 1'b0;
    #1 chk("mid_rst_state", {28'h0, State}, 32'd0);
    chk("mid_rst_en", {28'h0, enables()}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    Instr = 32'h4A000000;
    #1 chk("post_rst_fetch", {28'h0, State, enables()}, {28'h0, 4'd0, 4'b1001});
    @(negedge clk);
    @(negedge clk);
    #1 chk("post_rst_bmi", {28'h0, State, enables()}, {28'h0, 4'd9, 4'b0000});
    @(negedge clk);
    #1 chk("post_rst_refetch", {28'h0, State}, 32'd0);

`ifdef ARM_MC_WAIT_EN
    reset = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("wait_hold", {26'h0, State, IRWrite, Fault}, {26'h0, 4'd0, 1'b0, 1'b0});
      @(negedge clk);
    end
    MemReady = 1'b1;
    #1 chk("wait_ready_en", {30'h0, IRWrite, PCWrite}, 32'd3);
    @(negedge clk);
    #1 chk("wait_decode", {28'h0, State}, 32'd1);

    reset = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    MemReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("to_nofault", {31'h0, Fault}, 32'd0);
      @(negedge clk);
    end
    #1 chk("to_fault", {27'h0, Fault, enables()}, {27'h0, 1'b1, 4'b0000});
    @(negedge clk);
    #1 chk("to_retry", {27'h0, State, Fault}, 32'd0);
    MemReady = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
